sdram_fifo_sched: RTL and testbench

// Burst scheduler between the user write/read FIFOs and the SDRAM arbiter. Watches FIFO fill

---
 rtl/sdram_fifo_sched_if.sv | 23 ++
 rtl/sdram_fifo_sched.sv | 151 +++++++++++++++
 tb/tb_sdram_fifo_sched.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_fifo_sched_if.sv
// Burst request/grant handshake between the FIFO scheduler (master) and the SDRAM arbiter (slave).
interface sdram_fifo_sched_if #(
  parameter int ADDR_W = 24
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_start;
  logic              wr_en;
  logic              wr_end;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_start;
  logic              rd_en;
  logic              rd_end;

  modport master (
    output wr_req, wr_start, rd_req, rd_start,
    input  wr_en, wr_end, rd_en, rd_end
  );

  modport slave (
    input  wr_req, wr_start, rd_req, rd_start,
    output wr_en, wr_end, rd_en, rd_end
  );
endinterface

// File: rtl/sdram_fifo_sched.sv
// Burst scheduler: watches the user FIFO levels, issues one write/read burst request at a time and
// manages the circular SDRAM buffer pointers plus the count of stored bursts.
module sdram_fifo_sched #(
  parameter int                 ADDR_W    = 24,
  parameter int                 FIFO_W    = 10,
  parameter logic [FIFO_W-1:0]  BURST_LEN = 10'd256,
  parameter logic [ADDR_W-1:0]  ADDR_MIN  = 24'h000000,
  parameter logic [ADDR_W-1:0]  ADDR_MAX  = 24'hFFFF00,
  parameter int                 CNT_W     = 17
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic              sched_clr,
  input  logic              rd_enable,
  input  logic [FIFO_W-1:0] wfifo_level,
  input  logic [FIFO_W-1:0] rfifo_level,
  input  logic [FIFO_W-1:0] rfifo_depth,
  sdram_fifo_sched_if.master arb,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic              buf_full,
  output logic              buf_empty
);

  localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CAPACITY = CNT_W'(((ADDR_MAX - ADDR_MIN) / BURST_A) + ADDR_W'(1));

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_WR_REQ    = 3'd2;
  localparam logic [2:0] S_WR_RUN    = 3'd3;
  localparam logic [2:0] S_RD_REQ    = 3'd4;
  localparam logic [2:0] S_RD_RUN    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              wr_req_q, wr_req_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] wr_start_q, wr_start_d;
  logic [ADDR_W-1:0] rd_start_q, rd_start_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              last_wr_q, last_wr_d;
  logic              clr_pend_q, clr_pend_d;

  logic              wr_ok, rd_ok, in_run, end_now, clr_now;
  logic [FIFO_W-1:0] rd_room;

  always_comb begin
    state_d    = state_q;
    wr_req_d   = wr_req_q;
    rd_req_d   = rd_req_q;
    wr_start_d = wr_start_q;
    rd_start_d = rd_start_q;
    cnt_d      = cnt_q;
    last_wr_d  = last_wr_q;
    clr_pend_d = clr_pend_q;

    rd_room = rfifo_depth - rfifo_level;
    wr_ok   = (wfifo_level >= BURST_LEN) && !full_q;
    rd_ok   = rd_enable && !empty_q && (rd_room >= BURST_LEN);
    in_run  = (state_q == S_WR_RUN) || (state_q == S_RD_RUN);
    end_now = ((state_q == S_WR_RUN) && arb.wr_end) || ((state_q == S_RD_RUN) && arb.rd_end);

    case (state_q)
      S_WAIT_INIT: if (init_end) state_d = S_IDLE;
      S_IDLE: begin
        // On contention serve whichever direction was not served last.
        if (wr_ok && (!rd_ok || !last_wr_q)) begin
          state_d  = S_WR_REQ;
          wr_req_d = 1'b1;
        end else if (rd_ok) begin
          state_d  = S_RD_REQ;
          rd_req_d = 1'b1;
        end
      end
      S_WR_REQ: if (arb.wr_en) begin
        wr_req_d = 1'b0;
        state_d  = S_WR_RUN;
      end
      S_WR_RUN: if (arb.wr_end) begin
        state_d    = S_IDLE;
        wr_start_d = (wr_start_q == ADDR_MAX) ? ADDR_MIN : wr_start_q + BURST_A;
        if (!full_q) cnt_d = cnt_q + CNT_W'(1);
        last_wr_d  = 1'b1;
      end
      S_RD_REQ: if (arb.rd_en) begin
        rd_req_d = 1'b0;
        state_d  = S_RD_RUN;
      end
      S_RD_RUN: if (arb.rd_end) begin
        state_d    = S_IDLE;
        rd_start_d = (rd_start_q == ADDR_MAX) ? ADDR_MIN : rd_start_q + BURST_A;
        if (!empty_q) cnt_d = cnt_q - CNT_W'(1);
        last_wr_d  = 1'b0;
      end
      default: state_d = S_WAIT_INIT;
    endcase

    // A flush during a running burst waits for that burst to finish and then discards its update.
    clr_now = in_run ? (end_now && (clr_pend_q || sched_clr)) : sched_clr;
    if (in_run && sched_clr && !end_now) clr_pend_d = 1'b1;
    if (clr_now) begin
      state_d    = (state_q == S_WAIT_INIT) ? S_WAIT_INIT : S_IDLE;
      wr_req_d   = 1'b0;
      rd_req_d   = 1'b0;
      wr_start_d = ADDR_MIN;
      rd_start_d = ADDR_MIN;
      cnt_d      = '0;
      clr_pend_d = 1'b0;
    end

    full_d  = (cnt_d == CAPACITY);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_WAIT_INIT;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_start_q <= ADDR_MIN;
      rd_start_q <= ADDR_MIN;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      last_wr_q  <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      last_wr_q  <= last_wr_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign arb.wr_req   = wr_req_q;
  assign arb.wr_start = wr_start_q;
  assign arb.rd_req   = rd_req_q;
  assign arb.rd_start = rd_start_q;
  assign burst_cnt    = cnt_q;
  assign buf_full     = full_q;
  assign buf_empty    = empty_q;

endmodule

// File: tb/tb_sdram_fifo_sched.sv
// Directed bench for sdram_fifo_sched: small 4-burst buffer, scoreboard of expected requests
// checked by a monitor, plus direct status checks after each phase.
module tb_sdram_fifo_sched;

  typedef struct {
    bit          is_wr;
    logic [23:0] start;
    logic [16:0] cnt;
  } req_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic        sched_clr;
  logic        rd_enable;
  logic [9:0]  wfifo_level;
  logic [9:0]  rfifo_level;
  logic [9:0]  rfifo_depth;
  logic [16:0] burst_cnt;
  logic        buf_full;
  logic        buf_empty;

  int   n_chk  = 0;
  int   n_fail = 0;
  req_t exp_q[$];

  sdram_fifo_sched_if #(.ADDR_W(24)) bus ();

  sdram_fifo_sched #(
    .ADDR_W(24), .FIFO_W(10), .BURST_LEN(10'd256),
    .ADDR_MIN(24'h000000), .ADDR_MAX(24'h000300), .CNT_W(17)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .sched_clr(sched_clr),
    .rd_enable(rd_enable), .wfifo_level(wfifo_level), .rfifo_level(rfifo_level),
    .rfifo_depth(rfifo_depth), .arb(bus), .burst_cnt(burst_cnt),
    .buf_full(buf_full), .buf_empty(buf_empty)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_req(input bit is_wr, input logic [23:0] start, input logic [16:0] cnt);
    req_t r;
    r.is_wr = is_wr;
    r.start = start;
    r.cnt   = cnt;
    exp_q.push_back(r);
  endtask

  // Monitor: every rising request is matched against the head of the scoreboard.
  initial begin
    logic wr_prev, rd_prev;
    req_t r;
    wr_prev = 1'b0;
    rd_prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (bus.wr_req || bus.rd_req) chk("one_req_only", {31'd0, bus.wr_req && bus.rd_req}, 32'd0);
      if ((bus.wr_req && !wr_prev) || (bus.rd_req && !rd_prev)) begin
        $display("req %s start=%h cnt=%0d", bus.wr_req ? "WR" : "RD",
                 bus.wr_req ? bus.wr_start : bus.rd_start, burst_cnt);
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("req_kind", {31'd0, bus.wr_req}, {31'd0, r.is_wr});
          chk("req_start", {8'd0, (bus.wr_req ? bus.wr_start : bus.rd_start)}, {8'd0, r.start});
          chk("req_cnt", {15'd0, burst_cnt}, {15'd0, r.cnt});
        end
      end
      wr_prev = bus.wr_req;
      rd_prev = bus.rd_req;
    end
  end

  // Arbiter stand-in; mode 1 pulses sched_clr mid-burst, mode 2 asserts sys_rst mid-burst.
  task automatic grant(input bit is_wr, input int mode);
    int t;
    t = 0;
    while (!(is_wr ? bus.wr_req : bus.rd_req) && t < 50) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 50) begin
      chk(is_wr ? "wr_req_timeout" : "rd_req_timeout", 32'd1, 32'd0);
      return;
    end
    if (is_wr) bus.wr_en = 1'b1; else bus.rd_en = 1'b1;
    @(negedge sys_clk);
    chk("req_drop_after_en", {31'd0, is_wr ? bus.wr_req : bus.rd_req}, 32'd0);
    if (mode == 2) begin
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst   = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      return;
    end
    if (mode == 1) begin
      sched_clr = 1'b1;
      @(negedge sys_clk);
      sched_clr = 1'b0;
    end
    @(negedge sys_clk);
    if (is_wr) bus.wr_end = 1'b1; else bus.rd_end = 1'b1;
    @(negedge sys_clk);
    bus.wr_end = 1'b0;
    bus.rd_end = 1'b0;
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
  endtask

  task automatic check_status(input logic [23:0] wr_s, input logic [23:0] rd_s,
                              input logic [16:0] cnt, input bit full, input bit empty);
    chk("wr_start", {8'd0, bus.wr_start}, {8'd0, wr_s});
    chk("rd_start", {8'd0, bus.rd_start}, {8'd0, rd_s});
    chk("burst_cnt", {15'd0, burst_cnt}, {15'd0, cnt});
    chk("buf_full", {31'd0, buf_full}, {31'd0, full});
    chk("buf_empty", {31'd0, buf_empty}, {31'd0, empty});
  endtask

  task automatic quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge sys_clk);
      if (bus.wr_req || bus.rd_req) begin
        chk("no_req_expected", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; init_end = 1'b0; sched_clr = 1'b0; rd_enable = 1'b0;
    wfifo_level = 10'd256; rfifo_level = 10'd0; rfifo_depth = 10'd512;
    bus.wr_en = 1'b0; bus.wr_end = 1'b0; bus.rd_en = 1'b0; bus.rd_end = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_wr_req", {31'd0, bus.wr_req}, 32'd0);
    chk("rst_rd_req", {31'd0, bus.rd_req}, 32'd0);
    check_status(24'h000000, 24'h000000, 17'd0, 1'b0, 1'b1);
    quiet(3);

    // First write: request appears on the second edge after init_end.
    expect_req(1'b1, 24'h000000, 17'd0);
    init_end = 1'b1;
    @(negedge sys_clk);
    chk("wr_req_cycle1", {31'd0, bus.wr_req}, 32'd0);
    @(negedge sys_clk);
    chk("wr_req_cycle2", {31'd0, bus.wr_req}, 32'd1);
    grant(1'b1, 0);
    check_status(24'h000100, 24'h000000, 17'd1, 1'b0, 1'b0);

    // Both eligible: last served was write, so read, write, read, write.
    rd_enable = 1'b1;
    expect_req(1'b0, 24'h000000, 17'd1); grant(1'b0, 0);
    expect_req(1'b1, 24'h000100, 17'd0); grant(1'b1, 0);
    expect_req(1'b0, 24'h000100, 17'd1); grant(1'b0, 0);
    expect_req(1'b1, 24'h000200, 17'd0); grant(1'b1, 0);
    check_status(24'h000300, 24'h000200, 17'd1, 1'b0, 1'b0);

    // Fill the buffer; first of these wraps 0x300 -> 0x000.
    rd_enable = 1'b0;
    expect_req(1'b1, 24'h000300, 17'd1); grant(1'b1, 0);
    chk("wr_wrap", {8'd0, bus.wr_start}, 32'h000000);
    expect_req(1'b1, 24'h000000, 17'd2); grant(1'b1, 0);
    expect_req(1'b1, 24'h000100, 17'd3); grant(1'b1, 0);
    check_status(24'h000200, 24'h000200, 17'd4, 1'b1, 1'b0);
    quiet(10);

    // Read room 255 < burst: no read; room 256: read proceeds.
    wfifo_level = 10'd0;
    rd_enable   = 1'b1;
    rfifo_level = 10'd257;
    quiet(10);
    rfifo_level = 10'd256;
    expect_req(1'b0, 24'h000200, 17'd4); grant(1'b0, 0);
    check_status(24'h000200, 24'h000300, 17'd3, 1'b0, 1'b0);

    // Drain to empty; rd_start wraps 0x300 -> 0x000.
    expect_req(1'b0, 24'h000300, 17'd3); grant(1'b0, 0);
    expect_req(1'b0, 24'h000000, 17'd2); grant(1'b0, 0);
    expect_req(1'b0, 24'h000100, 17'd1); grant(1'b0, 0);
    check_status(24'h000200, 24'h000200, 17'd0, 1'b0, 1'b1);
    quiet(10);

    // Flush mid write burst: burst's update is discarded, pointers return to base.
    rd_enable   = 1'b0;
    wfifo_level = 10'd256;
    expect_req(1'b1, 24'h000200, 17'd0);
    grant(1'b1, 1);
    wfifo_level = 10'd0;
    check_status(24'h000000, 24'h000000, 17'd0, 1'b0, 1'b1);

    // Reset during a read burst.
    wfifo_level = 10'd256;
    expect_req(1'b1, 24'h000000, 17'd0); grant(1'b1, 0);
    wfifo_level = 10'd0;
    rd_enable   = 1'b1;
    rfifo_level = 10'd0;
    expect_req(1'b0, 24'h000000, 17'd1);
    grant(1'b0, 2);
    chk("rst_run_rd_req", {31'd0, bus.rd_req}, 32'd0);
    check_status(24'h000000, 24'h000000, 17'd0, 1'b0, 1'b1);
    quiet(5);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
